hex_display_scanner: RTL and testbench
======================================

# hex_display_scanner

Time-multiplexed controller for a single shared 7-segment decoder driving a DIGITS-wide common-anode display. Two requesters, the processor (Cpu) and the debug path (Dbg), submit hex values over valid/ready handshakes. A round-robin arbiter grants one requester at a time, and new values are committed only at frame boundaries, so the display never tears. The block sits between the processor's output register and the board's segment/digit pins.

## Interface
- DIGITS, 4, number of hex digits scanned (data width = 4*DIGITS)
- SCAN_DIV, 50000, clock cycles each digit is lit; must be ≥ 2

- Clk  in  1  system clock, rising edge
- ResetN  in  1  asynchronous, active-low reset
- CpuValid  in  1  Cpu request; held until accepted
- CpuData  in  4*DIGITS  Cpu value; stable while CpuValid is high
- CpuReady  out  1  Cpu may transfer this cycle
- DbgValid  in  1  Dbg request
- DbgData  in  4*DIGITS  Dbg value
- DbgReady  out  1  Dbg may transfer this cycle
- Owner  out  1  source of the displayed value (0 = Cpu, 1 = Dbg)
- Hex  out  [0:6]  active-low segments a..g; Hex[0] = a
- DigitN  out  DIGITS  active-low digit enable, one-hot-low; bit 0 is the least significant digit

## Operation
- Registers:
  - shown value and shown-valid flag
  - pending value, pending-valid flag and pending owner
  - last-grant bit
  - divider 0..SCAN_DIV-1
  - digit index 0..DIGITS-1
- Reset values:
  - shown-valid = 0, pending-valid = 0, last-grant = Dbg (so Cpu wins the first tie)
  - divider = 0, index = 0
  - Hex = 7'b1111110 (dash), DigitN = all ones except bit 0 low
  - CpuReady = DbgReady = 1, Owner = 0
- Handshake:
  - CpuReady = DbgReady = !pending-valid (combinational from the register).
  - A transfer occurs on a rising edge where Valid && Ready.
- Arbitration when both requesters are valid in the same cycle:
  - Grant the requester that was not granted last.
  - The loser sees Ready fall and must keep Valid asserted.
- On grant:
  - Load the pending value and owner, and set pending-valid.
  - Ready drops on the following cycle.
- Scan:
  - The divider increments every cycle; tick = (divider == SCAN_DIV-1), and on tick the divider wraps to 0.
  - On tick, index increments and wraps from DIGITS-1 to 0.
  - Frame end = tick with index == DIGITS-1.
- Commit at frame end when pending-valid is set:
  - shown ← pending, Owner ← pending owner, shown-valid ← 1, pending-valid ← 0.
  - If a grant coincides with frame end, the grant loads pending and is committed at the next frame end.
- Decode for the current index:
  - shown-valid = 0: dash on every digit.
  - shown-valid = 1: 7-seg pattern of nibble[index], using the standard 0–F table.
- Reset asserted mid-frame or mid-pending: the state is discarded immediately and asynchronously. Any accepted-but-uncommitted value is lost.

## Timing
- Hex and DigitN are registered and reflect the index one cycle after it changes.
  - Each digit is lit for exactly SCAN_DIV cycles.
  - A frame is DIGITS*SCAN_DIV cycles.
- Owner updates in the same edge as the shown value.
- Accept-to-display latency:
  - At most one frame plus 1 cycle until the committed value appears on digit 0.
  - Full value visible within 2 frames.
- Ready returns high 1 cycle after commit. Back-to-back accepts are therefore limited to one per frame.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Digits above the most significant nonzero nibble output 7'b1111111 (blank).
  - Digit 0 is never blanked, so a value of 0 displays "0".
- LEADING_ZERO_BLANK_EN undefined: every digit shows its nibble, including leading zeros.
- The dash display (shown-valid = 0) takes priority over blanking in both builds.

## Structure
- Package display_pkg:
  - SEG_DASH = 7'b1111110, SEG_BLANK = 7'b1111111
  - the 16-entry segment table
  - owner_t enum {OWN_CPU, OWN_DBG}
- Sub-module seg7_nibble_decode: combinational nibble → pattern, instantiated once and shared across digits via the index mux.
- The rest (arbiter, divider, index counter, commit logic) lives in the top module.

## Test plan
(Benches use DIGITS = 4, SCAN_DIV = 4, so a frame is 16 cycles.)
- Reset: pulse ResetN low mid-scan with a value pending → immediately Hex = 1111110, DigitN = 1110, both Ready = 1; dash on all digits for the whole next frame.
- Cpu writes 16'h1A3F → CpuReady = 0 next cycle. After frame end: digit0 = 0111000, digit1 = 0000110, digit2 = 0001000, digit3 = 1001111; Owner = 0; CpuReady = 1 one cycle after commit.
- CpuValid and DbgValid raised together after reset → Cpu granted first (16'h1111). Dbg holds Valid and is granted after the next commit → Owner = 1, display shows Dbg data.
- Grant on the frame-end edge → value appears only after the following frame end, never a partial frame.
- 16'h0007 with LEADING_ZERO_BLANK_EN → digits 3..1 = 1111111, digit0 = 0001111. Without the macro → digits 3..1 = 0000001. 16'h0000 with the macro → digit0 = 0000001.
- Scan cadence: DigitN walks 1110 → 1101 → 1011 → 0111 → 1110, each step held for exactly 4 cycles.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared segment patterns and owner type for the hex display scanner.
package display_pkg;
  localparam logic [0:6] SEG_DASH  = 7'b1111110;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  // Active-low a..g, index 0 = segment a.
  localparam logic [0:6] SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  typedef enum logic {OWN_CPU, OWN_DBG} owner_t;
endpackage

// File: rtl/seg7_nibble_decode.sv
// seg7_nibble_decode: combinational hex nibble to active-low 7-segment pattern.
module seg7_nibble_decode
  import display_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [0:6] o_seg
);
  assign o_seg = SEG_TABLE[i_nib];
endmodule

// File: rtl/hex_display_scanner.sv
// hex_display_scanner: two-requester round-robin hex value display with frame-aligned commit.
// Define LEADING_ZERO_BLANK_EN to blank digits above the most significant nonzero nibble.
module hex_display_scanner
  import display_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                Clk,
  input  logic                ResetN,
  input  logic                CpuValid,
  input  logic [4*DIGITS-1:0] CpuData,
  output logic                CpuReady,
  input  logic                DbgValid,
  input  logic [4*DIGITS-1:0] DbgData,
  output logic                DbgReady,
  output logic                Owner,
  output logic [0:6]          Hex,
  output logic [DIGITS-1:0]   DigitN
);
  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [CW-1:0]     r_div;
  logic [IW-1:0]     r_idx;
  logic [DW-1:0]     r_shown, r_pend_val;
  logic              r_shown_valid, r_pend_valid, r_last_dbg;
  owner_t            r_pend_owner, r_owner;
  logic [0:6]        r_hex;
  logic [DIGITS-1:0] r_digit_n;
  logic              w_tick, w_last, w_frame_end, w_cpu_go, w_dbg_go, w_blank;
  logic [3:0]        w_nib;
  logic [0:6]        w_seg;
  assign w_tick      = r_div == CW'(SCAN_DIV - 1);
  assign w_last      = r_idx == IW'(DIGITS - 1);
  assign w_frame_end = w_tick && w_last;
  assign CpuReady    = !r_pend_valid;
  assign DbgReady    = !r_pend_valid;
  // On a tie the requester not granted last wins.
  assign w_cpu_go    = CpuValid && !r_pend_valid && (!DbgValid || r_last_dbg);
  assign w_dbg_go    = DbgValid && !r_pend_valid && (!CpuValid || !r_last_dbg);
  assign w_nib       = r_shown[{r_idx, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
  logic [DW-1:0] w_upper;
  assign w_upper = r_shown >> {r_idx, 2'b00};
  assign w_blank = r_idx != '0 && w_upper == '0;
`else
  assign w_blank = 1'b0;
`endif
  seg7_nibble_decode u_dec (.i_nib(w_nib), .o_seg(w_seg));
  always_ff @(posedge Clk or negedge ResetN)
    if (!ResetN) begin
      r_div         <= '0;
      r_idx         <= '0;
      r_shown       <= '0;
      r_shown_valid <= 1'b0;
      r_pend_val    <= '0;
      r_pend_valid  <= 1'b0;
      r_pend_owner  <= OWN_CPU;
      r_owner       <= OWN_CPU;
      r_last_dbg    <= 1'b1;
      r_hex         <= SEG_DASH;
      r_digit_n     <= ~DIGITS'(1);
    end else begin
      r_div <= w_tick ? '0 : r_div + CW'(1);
      if (w_tick) r_idx <= w_last ? '0 : r_idx + IW'(1);
      if (r_pend_valid && w_frame_end) begin
        r_shown       <= r_pend_val;
        r_owner       <= r_pend_owner;
        r_shown_valid <= 1'b1;
        r_pend_valid  <= 1'b0;
      end else if (w_cpu_go || w_dbg_go) begin
        r_pend_val   <= w_dbg_go ? DbgData : CpuData;
        r_pend_owner <= w_dbg_go ? OWN_DBG : OWN_CPU;
        r_pend_valid <= 1'b1;
        r_last_dbg   <= w_dbg_go;
      end
      r_hex     <= !r_shown_valid ? SEG_DASH : w_blank ? SEG_BLANK : w_seg;
      r_digit_n <= ~(DIGITS'(1) << r_idx);
    end
  assign Owner  = r_owner;
  assign Hex    = r_hex;
  assign DigitN = r_digit_n;
endmodule

// File: tb/tb_hex_display_scanner.sv
// tb_hex_display_scanner: randomized and directed checks against a frame-time reference model.
module tb_hex_display_scanner;
  logic        Clk = 0, ResetN = 1, CpuValid = 0, DbgValid = 0;
  logic [15:0] CpuData = 0, DbgData = 0;
  logic        CpuReady, DbgReady, Owner;
  logic [0:6]  Hex;
  logic [3:0]  DigitN;
  int n_cmp = 0, n_bad = 0;
  int m_k;
  logic [15:0] m_shown, m_pend;
  bit m_sv, m_pv, m_pown, m_owner, m_last_dbg, m_cg, m_dg;
  logic [0:6] cap [4];
  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  localparam logic [6:0] E_BLANK_OR_ZERO =
`ifdef LEADING_ZERO_BLANK_EN
    7'b1111111;
`else
    7'b0000001;
`endif
  hex_display_scanner #(.DIGITS(4), .SCAN_DIV(4)) dut (
    .Clk(Clk), .ResetN(ResetN),
    .CpuValid(CpuValid), .CpuData(CpuData), .CpuReady(CpuReady),
    .DbgValid(DbgValid), .DbgData(DbgData), .DbgReady(DbgReady),
    .Owner(Owner), .Hex(Hex), .DigitN(DigitN)
  );
  always #5 Clk = ~Clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [6:0] m_seg(logic [15:0] v, bit sv, int idx);
    logic [15:0] up;
    up = v >> (4 * idx);
    if (!sv) return 7'b1111110;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && up == 0) return 7'b1111111;
`endif
    return seg_tab[up[3:0]];
  endfunction
  task automatic m_reset();
    m_k = 0; m_sv = 0; m_pv = 0; m_owner = 0; m_last_dbg = 1; m_shown = 0; m_pend = 0; m_pown = 0;
  endtask
  // One clock: predict from time-since-reset, step the model, compare, retire accepted requests.
  task automatic cyc();
    int idx;
    bit fe;
    logic [6:0] eh;
    logic [3:0] ed;
    idx = (m_k / 4) % 4;
    fe = (m_k % 16) == 15;
    eh = m_seg(m_shown, m_sv, idx);
    ed = ~(4'b0001 << idx);
    m_cg = 0; m_dg = 0;
    if (!m_pv) begin
      if (CpuValid && DbgValid) begin m_dg = !m_last_dbg; m_cg = m_last_dbg; end
      else begin m_cg = CpuValid; m_dg = DbgValid; end
    end
    @(posedge Clk);
    if (m_pv && fe) begin
      m_shown = m_pend; m_owner = m_pown; m_sv = 1; m_pv = 0;
    end else if (m_cg || m_dg) begin
      m_pend = m_dg ? DbgData : CpuData; m_pown = m_dg; m_pv = 1; m_last_dbg = m_dg;
    end
    m_k++;
    #1;
    check("hex", 32'(Hex), 32'(eh));
    check("digit_n", 32'(DigitN), 32'(ed));
    check("cpu_ready", 32'(CpuReady), 32'(!m_pv));
    check("dbg_ready", 32'(DbgReady), 32'(!m_pv));
    check("owner", 32'(Owner), 32'(m_owner));
    if (m_cg) CpuValid = 0;
    if (m_dg) DbgValid = 0;
  endtask
  task automatic cap_frame();
    repeat (16) begin
      cyc();
      for (int i = 0; i < 4; i++) if (DigitN == ~(4'b0001 << i)) cap[i] = Hex;
    end
  endtask
  task automatic chk_frame(string tag, logic [6:0] e3, logic [6:0] e2, logic [6:0] e1, logic [6:0] e0);
    check({tag, "_d3"}, 32'(cap[3]), 32'(e3));
    check({tag, "_d2"}, 32'(cap[2]), 32'(e2));
    check({tag, "_d1"}, 32'(cap[1]), 32'(e1));
    check({tag, "_d0"}, 32'(cap[0]), 32'(e0));
  endtask
  task automatic mid_reset();
    #1 ResetN = 0; CpuValid = 0; DbgValid = 0;
    #1;
    check("mid_rst_hex", 32'(Hex), 32'(7'b1111110));
    check("mid_rst_digit_n", 32'(DigitN), 32'(4'b1110));
    check("mid_rst_ready", 32'({CpuReady, DbgReady}), 32'(2'b11));
    #2 ResetN = 1;
    m_reset();
  endtask
  initial begin
    int n;
    m_reset();
    #2 ResetN = 0;
    #1;
    check("rst_hex", 32'(Hex), 32'(7'b1111110));
    check("rst_digit_n", 32'(DigitN), 32'(4'b1110));
    check("rst_ready", 32'({CpuReady, DbgReady}), 32'(2'b11));
    check("rst_owner", 32'(Owner), 32'(0));
    repeat (2) @(posedge Clk);
    #4 ResetN = 1;
    m_reset();
    CpuData = 16'h1A3F; CpuValid = 1;
    cyc();
    check("cpu_ready_drop", 32'(CpuReady), 32'(0));
    repeat (31) cyc();
    cap_frame();
    chk_frame("v1a3f", 7'b1001111, 7'b0001000, 7'b0000110, 7'b0111000);
    check("v1a3f_owner", 32'(Owner), 32'(0));
    CpuData = 16'hBEEF; CpuValid = 1;
    repeat (3) cyc();
    mid_reset();
    repeat (16) cyc();
    CpuData = 16'h1111; DbgData = 16'h2222; CpuValid = 1; DbgValid = 1;
    cyc();
    check("tie_dbg_held", 32'(DbgValid), 32'(1));
    repeat (15) cyc();
    check("tie_owner_cpu", 32'(Owner), 32'(0));
    cap_frame();
    chk_frame("tie_cpu", 7'b1001111, 7'b1001111, 7'b1001111, 7'b1001111);
    cap_frame();
    chk_frame("tie_dbg", 7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010);
    check("tie_owner_dbg", 32'(Owner), 32'(1));
    while (m_k % 16 != 15) cyc();
    CpuData = 16'h0008; CpuValid = 1;
    cyc();
    n = 0;
    do begin cyc(); n++; end while (!(DigitN == 4'b1110 && Hex == 7'b0000000) && n < 40);
    check("fe_grant_latency", 32'(n), 32'(17));
    CpuData = 16'h0007; CpuValid = 1;
    repeat (32) cyc();
    cap_frame();
    chk_frame("v0007", E_BLANK_OR_ZERO, E_BLANK_OR_ZERO, E_BLANK_OR_ZERO, 7'b0001111);
    CpuData = 16'h0000; CpuValid = 1;
    repeat (32) cyc();
    cap_frame();
    chk_frame("v0000", E_BLANK_OR_ZERO, E_BLANK_OR_ZERO, E_BLANK_OR_ZERO, 7'b0000001);
    repeat (400) begin
      if (!CpuValid && $urandom_range(0, 3) == 0) begin CpuData = 16'($urandom); CpuValid = 1; end
      if (!DbgValid && $urandom_range(0, 3) == 0) begin DbgData = 16'($urandom); DbgValid = 1; end
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
